// File: rtl/uop_block_arb.sv
// Round-robin arbiter for a shared fixed-latency uop datapath, with credit-limited result FIFO.
// Optional perf counters are enabled by defining UOP_BLOCK_ARB_PERF_EN.
module uop_block_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SW   = $clog2(W),
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*W-1:0]    req_src_i,
  input  logic [NREQ*SW-1:0]   req_shamt_i,
  output logic [W-1:0]         dp_src_o,
  output logic [SW-1:0]        dp_shamt_o,
  input  logic [W-1:0]         dp_dst_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [W-1:0]         rsp_data_o,
`ifdef UOP_BLOCK_ARB_PERF_EN
  output logic [31:0]          perf_issue_o,
  output logic [31:0]          perf_stall_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned IW1 = IDW + 1;

  // Arbitration
  logic [IDW-1:0] r_rr;
  logic           w_gnt_found;
  logic [IDW-1:0] w_gnt_idx;
  logic [CW-1:0]  r_used;
  logic           w_credit;
  logic           w_issue;
  logic [W-1:0]   w_sel_src;
  logic [SW-1:0]  w_sel_shamt;

  always_comb begin
    logic [IW1-1:0] v_sum;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_sum       = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_sum = {1'b0, r_rr} + IW1'(i);
      if (v_sum >= IW1'(NREQ)) v_sum = v_sum - IW1'(NREQ);
      if (!w_gnt_found && req_valid_i[v_sum[IDW-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_sum[IDW-1:0];
      end
    end
  end

  // Credit covers both in-flight tags and held FIFO entries, so a capture never overflows.
  assign w_credit    = (r_used < CW'(DEPTH));
  assign w_issue     = w_gnt_found & w_credit & rst_n;
  assign req_ready_o = w_issue ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_sel_src   = req_src_i[w_gnt_idx*W +: W];
  assign w_sel_shamt = req_shamt_i[w_gnt_idx*SW +: SW];

  logic [W-1:0]  r_dp_src;
  logic [SW-1:0] r_dp_shamt;

  assign dp_src_o   = w_issue ? w_sel_src   : r_dp_src;
  assign dp_shamt_o = w_issue ? w_sel_shamt : r_dp_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_dp_src   <= '0;
      r_dp_shamt <= '0;
    end else if (w_issue) begin
      r_rr       <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
      r_dp_src   <= w_sel_src;
      r_dp_shamt <= w_sel_shamt;
    end
  end

  // Tag pipeline tracks ownership of each result through the datapath
  logic [LAT-1:0] r_tag_vld;
  logic [IDW-1:0] r_tag_id [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  // Result FIFO
  logic           w_push;
  logic           w_pop;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_fifo_data [DEPTH];
  logic [IDW-1:0] r_fifo_id   [DEPTH];

  assign w_push      = r_tag_vld[LAT-1];
  assign rsp_valid_o = (r_cnt != '0);
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  assign rsp_id_o    = rsp_valid_o ? r_fifo_id[r_rd]   : '0;
  assign rsp_data_o  = rsp_valid_o ? r_fifo_data[r_rd] : '0;
  assign busy_o      = (|r_tag_vld) | rsp_valid_o;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr] <= dp_dst_i;
      r_fifo_id[r_wr]   <= r_tag_id[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_used <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      unique case ({w_issue, w_pop})
        2'b10:   r_used <= r_used + CW'(1);
        2'b01:   r_used <= r_used - CW'(1);
        default: r_used <= r_used;
      endcase
    end
  end

`ifdef UOP_BLOCK_ARB_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue) r_perf_issue <= r_perf_issue + 32'd1;
      else if (|req_valid_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issue_o = r_perf_issue;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule
